// File: rtl/readout_pkg.sv
// Shared definitions for the memory readout streamer: FSM state encoding and
// helpers that derive byte-lane and timeout-counter widths from the module parameters.
package readout_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DATA = 3'd2,
    SEND      = 3'd3,
    NEXT      = 3'd4,
    CSUM      = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam int DEF_ADDR_W      = 30;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MEM_TIMEOUT = 1024;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/readout_byte_serializer.sv
// Holds one memory word and emits it LSB-byte-first to the TX FIFO under the full-flag
// handshake. With READOUT_CHECKSUM_EN defined it also keeps the running XOR of sent bytes.
module readout_byte_serializer
  import readout_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              send_data,
`ifdef READOUT_CHECKSUM_EN
  input  logic              clear_csum,
  input  logic              send_csum,
`endif
  input  logic              tx_buffer_full,
  output logic [7:0]        tx_data,
  output logic              tx_write,
  output logic              last_byte
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [BPW-1:0][7:0] data_q;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          cur_byte;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  assign cur_byte  = data_q[idx];
  assign last_byte = (idx == IDX_W'(BPW - 1));

  always_comb begin
    tx_write = 1'b0;
    tx_data  = cur_byte;
    if (send_data) tx_write = !tx_buffer_full;
`ifdef READOUT_CHECKSUM_EN
    if (send_csum) begin
      tx_data  = csum_q;
      tx_write = !tx_buffer_full;
    end
`endif
  end

  // A fresh load always restarts at byte 0; the index only moves on an accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      idx    <= '0;
`ifdef READOUT_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      if (load) begin
        data_q <= word;
        idx    <= '0;
      end else if (send_data && !tx_buffer_full) begin
        idx <= idx + 1'b1;
      end
`ifdef READOUT_CHECKSUM_EN
      if (clear_csum) csum_q <= '0;
      else if (send_data && !tx_buffer_full) csum_q <= csum_q ^ cur_byte;
`endif
    end
  end

endmodule

// File: rtl/mem_readout_streamer.sv
// Streams memory words addr_start..addr_end into the UART TX FIFO, one read outstanding,
// with range and read-timeout error reporting. READOUT_CHECKSUM_EN appends an XOR byte.
module mem_readout_streamer
  import readout_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W-1:0] addr_end,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_write,
  input  logic              tx_buffer_full
);

  localparam int TIMER_W = timer_width(MEM_TIMEOUT);

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  addr_q, addr_end_q;
  logic [TIMER_W-1:0] timer_q;
  logic               err_q;
  logic               range_bad, addr_is_last, timed_out, wr_ok;
  logic               ser_load, ser_send_data, ser_last;
`ifdef READOUT_CHECKSUM_EN
  logic               ser_send_csum, ser_clear;
`endif

  assign range_bad    = addr_end < addr_start;
  assign addr_is_last = addr_q == addr_end_q;
  assign timed_out    = timer_q == TIMER_W'(MEM_TIMEOUT - 1);
  assign wr_ok        = !tx_buffer_full && !reset;
  assign mem_rd_addr  = addr_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Address compare happens before the increment, so an all-ones end address never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      addr_end_q <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr_q     <= addr_start;
          addr_end_q <= addr_end;
          err_q      <= range_bad;
        end
        REQ:       timer_q <= '0;
        WAIT_DATA: begin
          timer_q <= timer_q + 1'b1;
          if (!mem_rd_valid && timed_out) err_q <= 1'b1;
        end
        NEXT:      if (!addr_is_last) addr_q <= addr_q + 1'b1;
        default:   ;
      endcase
    end
  end

  always_comb begin
    state_nx      = state;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    mem_rd_en     = 1'b0;
    ser_load      = 1'b0;
    ser_send_data = 1'b0;
`ifdef READOUT_CHECKSUM_EN
    ser_send_csum = 1'b0;
    ser_clear     = 1'b0;
`endif
    case (state)
      IDLE: if (start) begin
`ifdef READOUT_CHECKSUM_EN
        ser_clear = 1'b1;
`endif
        state_nx = range_bad ? DONE : REQ;
      end
      REQ: begin
        busy      = 1'b1;
        mem_rd_en = !reset;
        state_nx  = WAIT_DATA;
      end
      WAIT_DATA: begin
        busy = 1'b1;
        if (mem_rd_valid) begin
          ser_load = 1'b1;
          state_nx = SEND;
        end else if (timed_out) begin
          state_nx = DONE;
        end
      end
      SEND: begin
        busy          = 1'b1;
        ser_send_data = !reset;
`ifdef READOUT_CHECKSUM_EN
        if (wr_ok && ser_last) state_nx = addr_is_last ? CSUM : NEXT;
`else
        if (wr_ok && ser_last) state_nx = NEXT;
`endif
      end
      NEXT: begin
        busy     = 1'b1;
        state_nx = addr_is_last ? DONE : REQ;
      end
`ifdef READOUT_CHECKSUM_EN
      CSUM: begin
        busy          = 1'b1;
        ser_send_csum = !reset;
        if (wr_ok) state_nx = DONE;
      end
`endif
      DONE: begin
        done     = !reset;
        error    = err_q && !reset;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  readout_byte_serializer #(.DATA_W(DATA_W)) u_serializer (
    .clk            (clk),
    .reset          (reset),
    .load           (ser_load),
    .word           (mem_rd_data),
    .send_data      (ser_send_data),
`ifdef READOUT_CHECKSUM_EN
    .clear_csum     (ser_clear),
    .send_csum      (ser_send_csum),
`endif
    .tx_buffer_full (tx_buffer_full),
    .tx_data        (tx_data),
    .tx_write       (tx_write),
    .last_byte      (ser_last)
  );

endmodule

// File: tb/tb_mem_readout_streamer.sv
// Randomized self-checking bench for mem_readout_streamer: a behavioural memory, a TX FIFO
// full-flag generator and a queue-based model of the expected byte stream and read addresses.
module tb_mem_readout_streamer;

  localparam int ADDR_W      = 30;
  localparam int DATA_W      = 32;
  localparam int MEM_TIMEOUT = 1024;
  localparam int BPW         = DATA_W / 8;
  localparam int BUDGET      = 2000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] addr_start = '0;
  logic [ADDR_W-1:0] addr_end = '0;
  logic              busy, done, error, mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;
  logic [7:0]        tx_data;
  logic              tx_write;
  logic              tx_buffer_full;

  int testCount = 0;
  int failCount = 0;

  int  fullMode = 0;
  bit  respondEn = 1'b1;
  bit  spurious = 1'b0;
  int  maxLat = 1;
  bit  burstDone = 1'b0;
  int  burstLeft = 0;
  int  burstBase = 0;

  int   cyc = 0;
  int   rdCount = 0;
  int   doneCount = 0;
  int   wrTotal = 0;
  int   startCyc = 0;
  int   doneCyc = 0;
  int   rdCyc = 0;
  logic errAtDone = 1'b0;
  logic [7:0]        wrQ[$];
  logic [ADDR_W-1:0] rdQ[$];

  logic [7:0]        expBytes[$];
  logic [ADDR_W-1:0] expAddrs[$];
  logic              expErr;

  logic [DATA_W-1:0] memOverride [logic [ADDR_W-1:0]];

  mem_readout_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .addr_start     (addr_start),
    .addr_end       (addr_end),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data),
    .tx_data        (tx_data),
    .tx_write       (tx_write),
    .tx_buffer_full (tx_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    if (memOverride.exists(a)) return memOverride[a];
    return {a[13:0], a[29:12]} ^ 32'h6C8E_9CF5;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: every address in range is read once, each word contributes its bytes LSB first.
  task automatic buildExpected(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                               input bit withhold);
    logic [DATA_W-1:0] w;
    logic [7:0]        b8;
    logic [7:0]        csum;
    expBytes.delete();
    expAddrs.delete();
    csum = 8'h00;
    expErr = 1'b1;
    if (ea < sa) return;
    if (withhold) begin
      expAddrs.push_back(sa);
      return;
    end
    expErr = 1'b0;
    for (longint a = longint'(sa); a <= longint'(ea); a++) begin
      expAddrs.push_back(ADDR_W'(a));
      w = memWord(ADDR_W'(a));
      for (int b = 0; b < BPW; b++) begin
        b8 = w[8*b +: 8];
        expBytes.push_back(b8);
        csum = csum ^ b8;
      end
    end
`ifdef READOUT_CHECKSUM_EN
    expBytes.push_back(csum);
`endif
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (start && !busy && !done) startCyc = cyc;
      if (mem_rd_en) begin
        rdCount++;
        rdCyc = cyc;
        rdQ.push_back(mem_rd_addr);
      end
      if (tx_write) begin
        wrTotal++;
        wrQ.push_back(tx_data);
        checkOutput("no_write_while_full", tx_buffer_full, 0);
      end
      if (done) begin
        doneCount++;
        doneCyc = cyc;
        errAtDone = error;
        checkOutput("busy_low_at_done", busy, 0);
      end
    end
  end

  initial begin
    tx_buffer_full = 1'b0;
    forever begin
      @(negedge clk);
      case (fullMode)
        1: tx_buffer_full = ($urandom_range(0, 99) < 35);
        2: begin
          if (!burstDone && (wrTotal - burstBase) >= 2) begin
            burstLeft = 5;
            burstDone = 1'b1;
          end
          if (burstLeft > 0) begin
            tx_buffer_full = 1'b1;
            burstLeft--;
          end else begin
            tx_buffer_full = 1'b0;
          end
        end
        default: tx_buffer_full = 1'b0;
      endcase
    end
  end

  // Memory: answers each read after 1..maxLat cycles; optionally repeats a bogus valid pulse.
  initial begin
    logic [ADDR_W-1:0] ra;
    int lat;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mem_rd_en && respondEn) begin
        ra  = mem_rd_addr;
        lat = $urandom_range(1, maxLat);
        repeat (lat) @(negedge clk);
        mem_rd_valid = 1'b1;
        mem_rd_data  = memWord(ra);
        @(negedge clk);
        if (spurious) begin
          mem_rd_data = ~mem_rd_data;
          @(negedge clk);
        end
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
      end
    end
  end

  task automatic applyStimulus(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                               input int fm, input bit withhold, input bit extraStarts,
                               input int lat, input bit spur);
    int d0;
    int budget;
    int n;
    buildExpected(sa, ea, withhold);
    fullMode  = fm;
    respondEn = !withhold;
    maxLat    = lat;
    spurious  = spur;
    burstDone = 1'b0;
    burstBase = wrTotal;
    wrQ.delete();
    rdQ.delete();
    d0 = doneCount;
    @(negedge clk);
    start      = 1'b1;
    addr_start = sa;
    addr_end   = ea;
    @(negedge clk);
    start      = 1'b0;
    addr_start = ADDR_W'($urandom);
    addr_end   = ADDR_W'($urandom);
    #1;
    checkOutput("busy_after_start", busy, !(ea < sa));
    budget = BUDGET;
    while (doneCount == d0 && budget > 0) begin
      if (extraStarts && busy && $urandom_range(0, 3) == 0) begin
        start      = 1'b1;
        addr_start = ADDR_W'($urandom);
        addr_end   = ADDR_W'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      budget--;
    end
    fullMode = 0;
    repeat (4) @(negedge clk);
    #3;
    checkOutput("done_count", doneCount - d0, 1);
    checkOutput("error_flag", errAtDone, expErr);
    checkOutput("rd_count", rdQ.size(), expAddrs.size());
    n = (rdQ.size() < expAddrs.size()) ? rdQ.size() : expAddrs.size();
    for (int i = 0; i < n; i++) checkOutput($sformatf("rd_addr[%0d]", i), rdQ[i], expAddrs[i]);
    checkOutput("byte_count", wrQ.size(), expBytes.size());
    n = (wrQ.size() < expBytes.size()) ? wrQ.size() : expBytes.size();
    for (int i = 0; i < n; i++) checkOutput($sformatf("byte[%0d]", i), wrQ[i], expBytes[i]);
    checkOutput("busy_idle", busy, 0);
    if (withhold) checkOutput("timeout_latency", doneCyc - rdCyc, MEM_TIMEOUT + 1);
    if (ea < sa) checkOutput("range_err_latency", (doneCyc - startCyc) inside {[1:2]}, 1);
  endtask

  task automatic resetMidSend();
    int w0, d0, wSnap, rSnap, budget;
    fullMode  = 0;
    respondEn = 1'b1;
    maxLat    = 1;
    spurious  = 1'b0;
    w0 = wrTotal;
    d0 = doneCount;
    @(negedge clk);
    start      = 1'b1;
    addr_start = 30'h20;
    addr_end   = 30'h22;
    @(negedge clk);
    start = 1'b0;
    budget = 100;
    while (wrTotal < w0 + 2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("reached_send", (wrTotal - w0) >= 2, 1);
    wSnap = wrTotal;
    rSnap = rdCount;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    checkOutput("rst_no_writes", wrTotal, wSnap);
    checkOutput("rst_no_reads", rdCount, rSnap);
    checkOutput("rst_no_done", doneCount, d0);
    checkOutput("rst_idle", busy, 0);
  endtask

  initial begin
    logic [ADDR_W-1:0] sa, ea;
    int len;
    memOverride[30'h10] = 32'hA1B2_C3D4;
    memOverride[30'h11] = 32'h1122_3344;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_mem_rd_en", mem_rd_en, 0);
    checkOutput("rst_tx_write", tx_write, 0);
    checkOutput("rst_mem_rd_addr", mem_rd_addr, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(30'h10, 30'h11, 0, 1'b0, 1'b0, 1, 1'b0);
    applyStimulus(30'h10, 30'h11, 2, 1'b0, 1'b0, 2, 1'b0);
    applyStimulus(30'h5, 30'h4, 0, 1'b0, 1'b0, 1, 1'b0);
    applyStimulus(30'h33, 30'h35, 0, 1'b1, 1'b0, 1, 1'b0);
    applyStimulus(30'h3FFF_FFFF, 30'h3FFF_FFFF, 1, 1'b0, 1'b1, 3, 1'b0);
    resetMidSend();

    for (int r = 0; r < 25; r++) begin
      sa  = ADDR_W'($urandom) & ~30'h3;
      len = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) begin
        sa = sa + 30'h2;
        ea = sa - 30'h1 - ADDR_W'($urandom_range(0, 1));
      end else begin
        ea = sa + ADDR_W'(len);
      end
      applyStimulus(sa, ea, $urandom_range(0, 2), 1'b0, 1'(($urandom_range(0, 1))),
                    $urandom_range(1, 4), 1'(($urandom_range(0, 1))));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
